// File: rtl/icache_direct.sv
// rtl/icache_direct.sv - direct-mapped read-only instruction cache; define ICACHE_STATS_EN for hit/miss counters
module icache_direct #(
  parameter int SETS       = 64,
  parameter int LINE_WORDS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ireq_valid,
  input  logic [63:0] ireq_addr,
  output logic        iresp_addr_ok,
  output logic        iresp_data_ok,
  output logic [31:0] iresp_data,
  input  logic        flush,
  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [2:0]  creq_size,
  output logic [63:0] creq_addr,
  output logic [3:0]  creq_len,
  output logic [1:0]  creq_burst,
  input  logic        cresp_ready,
  input  logic        cresp_last,
  input  logic [63:0] cresp_data
`ifdef ICACHE_STATS_EN
  ,
  output logic [63:0] hit_cnt,
  output logic [63:0] miss_cnt
`endif
);

  localparam int OFF_W  = $clog2(8 * LINE_WORDS);
  localparam int IDX_W  = $clog2(SETS);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int TAG_LO = OFF_W + IDX_W;
  localparam int TAG_W  = 32 - TAG_LO;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REFILL,
    S_UNCACHED,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [63:0]       data_mem [0:SETS*LINE_WORDS-1];
  logic [TAG_W-1:0]  tag_mem  [0:SETS-1];
  logic [SETS-1:0]   valid_q;

  logic [63:0]       addr_q;
  logic [WSEL_W-1:0] cnt_q;
  logic              kill_q;
  logic [31:0]       udata_q;

  logic [IDX_W-1:0]  req_idx;
  logic [TAG_W-1:0]  req_tag;
  logic [WSEL_W-1:0] req_word;
  logic [IDX_W-1:0]  fill_idx;
  logic [63:0]       hit_word;
  logic [31:0]       hit_half;
  logic              hit;
  logic              done_ok;
  logic              beat_last;

  assign req_idx   = ireq_addr[TAG_LO-1:OFF_W];
  assign req_tag   = ireq_addr[31:TAG_LO];
  assign req_word  = ireq_addr[OFF_W-1:3];
  assign fill_idx  = addr_q[TAG_LO-1:OFF_W];
  assign hit_word  = data_mem[{req_idx, req_word}];
  assign hit_half  = ireq_addr[2] ? hit_word[63:32] : hit_word[31:0];
  assign beat_last = cresp_ready && cresp_last;

  // Lookup happens only in IDLE, so it never races a refill write to the same line
  assign hit = (state_q == S_IDLE) && ireq_valid && ireq_addr[31] &&
               valid_q[req_idx] && (tag_mem[req_idx] == req_tag);

  // A redirected fetch must not receive the stale uncached word
  assign done_ok = (state_q == S_DONE) && ireq_valid && (ireq_addr == addr_q);

  // Next-state and response/request outputs
  always_comb begin
    state_d       = state_q;
    iresp_addr_ok = hit || done_ok;
    iresp_data_ok = hit || done_ok;
    iresp_data    = 32'd0;
    creq_valid    = 1'b0;
    creq_is_write = 1'b0;
    creq_size     = 3'd3;
    creq_burst    = 2'b01;
    creq_addr     = {addr_q[63:3], 3'b000};
    creq_len      = 4'd0;

    if (hit) begin
      iresp_data = hit_half;
    end else if (done_ok) begin
      iresp_data = udata_q;
    end

    case (state_q)
      S_IDLE: begin
        if (ireq_valid && !hit) begin
          state_d = ireq_addr[31] ? S_REFILL : S_UNCACHED;
        end
      end
      S_REFILL: begin
        creq_valid = 1'b1;
        creq_addr  = {addr_q[63:OFF_W], {OFF_W{1'b0}}};
        creq_len   = 4'(LINE_WORDS - 1);
        if (beat_last) begin
          state_d = S_IDLE;
        end
      end
      S_UNCACHED: begin
        creq_valid = 1'b1;
        if (beat_last) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State, latched request, beat counter, kill flag and valid bits
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= 64'd0;
      cnt_q   <= '0;
      kill_q  <= 1'b0;
      udata_q <= 32'd0;
      valid_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        cnt_q  <= '0;
        kill_q <= 1'b0;
        if (ireq_valid && !hit) begin
          addr_q <= ireq_addr;
        end
      end
      if (state_q == S_REFILL) begin
        if (cresp_ready) begin
          cnt_q <= cnt_q + WSEL_W'(1);
        end
        if (flush) begin
          kill_q <= 1'b1;
        end
      end
      if (state_q == S_UNCACHED && beat_last) begin
        udata_q <= addr_q[2] ? cresp_data[63:32] : cresp_data[31:0];
      end
      // A flush in the final refill cycle also counts as a kill
      if (flush) begin
        valid_q <= '0;
      end else if (state_q == S_REFILL && beat_last && !kill_q) begin
        valid_q[fill_idx] <= 1'b1;
      end
    end
  end

  // Line data and tag fill; contents are meaningless until the valid bit is set
  always_ff @(posedge clk) begin
    if (state_q == S_REFILL && cresp_ready) begin
      data_mem[{fill_idx, cnt_q}] <= cresp_data;
      if (cresp_last) begin
        tag_mem[fill_idx] <= addr_q[31:TAG_LO];
      end
    end
  end

`ifdef ICACHE_STATS_EN
  // Saturating hit and miss counters; uncached traffic is not counted
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_cnt  <= 64'd0;
      miss_cnt <= 64'd0;
    end else begin
      if (hit && hit_cnt != '1) begin
        hit_cnt <= hit_cnt + 64'd1;
      end
      if (state_q == S_IDLE && state_d == S_REFILL && miss_cnt != '1) begin
        miss_cnt <= miss_cnt + 64'd1;
      end
    end
  end
`endif

endmodule

// File: doc/icache_direct.md
Name: icache_direct

Overview:
- Direct-mapped, read-only instruction cache between the core's instruction bus (ibus request/response) and the cache bus (CBus) toward the CBus arbiter/memory.
- Hits return in the same cycle as the request.
- Misses on cacheable addresses (addr[31]=1) refill a full line with a CBus INCR burst.
- Uncached addresses (addr[31]=0) bypass the array with a single-beat read.
- A flush input invalidates the whole array (fence.i / satp change).

Parameters:
SETS, 64, number of lines (power of 2)
LINE_WORDS, 8, 64-bit words per line (power of 2, max 16); line bytes = 8*LINE_WORDS

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
ireq_valid  in  1  ibus request valid; held until data_ok
ireq_addr  in  64  fetch address, 4-byte aligned
iresp_addr_ok  out  1  request accepted
iresp_data_ok  out  1  data valid this cycle
iresp_data  out  32  instruction
flush  in  1  invalidate all lines
creq_valid  out  1  CBus request valid
creq_is_write  out  1  constant 0
creq_size  out  3  constant MSIZE8 (3'd3)
creq_addr  out  64  line-aligned address (cached) or {addr[63:3],3'b0} (uncached)
creq_len  out  4  LINE_WORDS-1 (cached) or 0 (uncached)
creq_burst  out  2  AXI_BURST_INCR
cresp_ready  in  1  beat valid
cresp_last  in  1  final beat
cresp_data  in  64  beat data

Behaviour:
- Address split: offset = addr[log2(8*LINE_WORDS)-1:0]; index = next log2(SETS) bits; tag = addr[31:index_hi+1]. Word select = addr[offset_hi:3]; half = addr[2] (1 = upper 32 bits).
- Storage: data[SETS][LINE_WORDS] x 64, tag[SETS], valid[SETS]. Registered or LUT RAM, read combinationally.
- Reset (reset=0, async): all valid cleared, state IDLE, creq_valid=0, iresp_addr_ok=0, iresp_data_ok=0, iresp_data=0, beat counter 0.
- FSM states: IDLE, REFILL, UNCACHED, DONE.
- IDLE, cacheable hit (ireq_valid & addr[31] & valid[idx] & tag match):
  - iresp_addr_ok=iresp_data_ok=1 combinationally, same cycle; data selected from the array.
- IDLE, cacheable miss: latch addr -> REFILL.
- IDLE, uncached request: latch addr -> UNCACHED.
- REFILL:
  - creq_valid=1 (len=LINE_WORDS-1); beat counter starts at 0.
  - Each cresp_ready writes data[idx][cnt] and increments cnt.
  - On cresp_ready & cresp_last: write tag[idx] and set valid[idx] (unless killed, see flush) -> IDLE. The request then hits on the next cycle, so miss latency = beats + 1 cycles.
- UNCACHED:
  - creq_valid=1 (len=0). On cresp_ready & cresp_last, latch the selected 32-bit half -> DONE.
- DONE: iresp_addr_ok=iresp_data_ok=1 with the latched data for exactly one cycle -> IDLE. Uncached data is never written to the array.
- creq_* fields are stable while creq_valid=1. creq_valid deasserts the cycle after the last beat.
- ireq_valid dropping mid-REFILL/UNCACHED (pipeline redirect): the burst still completes (CBus cannot abort). The line is still installed; the DONE response is suppressed if ireq_valid=0 or ireq_addr differs from the latched address.
- Flush:
  - flush in IDLE clears all valid bits next edge; a simultaneous hit in that cycle is still served.
  - flush during REFILL sets a kill flag: the refill finishes but valid is not set. The kill flag clears on return to IDLE.
- Array write and lookup on the same index never overlap (lookup only in IDLE).

Optional Feature:
- ICACHE_STATS_EN: adds 64-bit outputs hit_cnt and miss_cnt.
  - hit_cnt increments on each IDLE hit handshake; miss_cnt increments on each entry to REFILL. UNCACHED accesses are not counted.
  - Both counters reset to 0 on reset and saturate at all-ones.
- Without the macro: no counters and no extra ports.

Test Plan:
- Cold miss at 0x8000_0000: one CBus burst, addr 0x8000_0000, len 7, 8 beats with data D0..D7. data_ok on the cycle after last. iresp_data=D0[31:0]. A following fetch of 0x8000_0004 hits same cycle with D0[63:32].
- Conflict: fetch 0x8000_0000 then 0x8000_1000 (same index, different tag) -> second one refills. Refetching 0x8000_0000 misses again.
- Uncached fetch 0x0000_1004: creq len 0, addr 0x0000_1000, beat 0x1111_2222_3333_4444 -> data_ok with 0x1111_2222. A second identical fetch issues another CBus read.
- Flush asserted mid-refill of 0x8000_0040: burst completes, no valid set; the next fetch of 0x8000_0040 issues a new burst.
- reset pulled low mid-REFILL (beat 3): creq_valid=0 immediately, all lines invalid. After release, fetch 0x8000_0000 misses.
- With ICACHE_STATS_EN: 1 miss + 3 hits -> miss_cnt=1, hit_cnt=3.
